// File: rtl/axi_pkg.sv
// Shared AXI encodings and read-slave FSM states.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts, plus WRAP length legality.
module axi_burst_addr_gen
  import axi_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [3:0]  len,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr,
  output logic        wrap_ok
);

  logic [31:0] step;
  logic [31:0] wrap_mask;

  // WRAP keeps the bits above the container fixed and rolls the low bits.
  always_comb begin
    step      = 32'd1 << size;
    wrap_mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
    wrap_ok   = wrap_len_ok(len);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = addr + step;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
      default:     next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_inst_rom_slave.sv
// Read-only AXI3 instruction memory slave with a side preload port.
module axi_inst_rom_slave #(
  parameter int unsigned DEPTH_LOG2   = 12,
  parameter logic [31:0] ADDR_BASE    = 32'hBFC0_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [31:0]           araddr,
  input  logic [3:0]            arid,
  input  logic [3:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [31:0]           rdata,
  output logic [3:0]            rid,
  output logic [1:0]            rresp,
  output logic                  rlast,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data
);
  import axi_pkg::*;

  localparam bit         ZERO_LAT = (READ_LATENCY == 0);
  localparam logic [2:0] LAT_INIT = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;

  logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

  state_t      state;
  logic [2:0]  lat_cnt;
  logic [3:0]  beat_cnt;
  logic [3:0]  len_q;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;

  logic [31:0] next_addr;
  logic        wrap_ok_q;
  logic        ar_fire;
  logic        beat_done;
  logic [31:0] ar_aligned;
  logic        fetch;
  logic [31:0] fetch_addr;
  logic        proto_err;
  logic [31:0] fetch_off;
  logic        fetch_err;
  logic [DEPTH_LOG2-1:0] fetch_idx;

  axi_burst_addr_gen u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr),
    .wrap_ok   (wrap_ok_q)
  );

  assign arready    = (state == S_IDLE) && !reset;
  assign rvalid     = (state == S_BURST);
  assign rlast      = rvalid && (beat_cnt == 4'd0);
  assign ar_fire    = arvalid && arready;
  assign beat_done  = rvalid && rready;
  assign ar_aligned = araddr & ~((32'd1 << arsize) - 32'd1);

  // Pick which beat address is read at this edge; data lands in rdata for the
  // following cycle, so the next beat is fetched on the current beat's handshake.
  always_comb begin
    fetch      = 1'b0;
    fetch_addr = addr_q;
    proto_err  = (size_q > 3'd2) || ((burst_q == BURST_WRAP) && !wrap_ok_q);
    case (state)
      S_IDLE: begin
        fetch      = ar_fire && ZERO_LAT;
        fetch_addr = ar_aligned;
        proto_err  = (arsize > 3'd2) || ((arburst == BURST_WRAP) && !wrap_len_ok(arlen));
      end
      S_WAIT: begin
        fetch = (lat_cnt == 3'd0);
      end
      S_BURST: begin
        fetch      = beat_done && (beat_cnt != 4'd0);
        fetch_addr = next_addr;
      end
      default: fetch = 1'b0;
    endcase
    fetch_off = fetch_addr - ADDR_BASE;
    fetch_idx = DEPTH_LOG2'(fetch_off >> 2);
    fetch_err = proto_err || (fetch_addr < ADDR_BASE) ||
                ((fetch_off >> (DEPTH_LOG2 + 2)) != '0);
  end

  // Preload port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  // Burst FSM with registered read data and response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      lat_cnt  <= '0;
      beat_cnt <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      rid      <= '0;
      rresp    <= '0;
      rdata    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ar_fire) begin
            addr_q   <= ar_aligned;
            len_q    <= arlen;
            size_q   <= arsize;
            burst_q  <= arburst;
            beat_cnt <= arlen;
            rid      <= arid;
            lat_cnt  <= LAT_INIT;
            state    <= ZERO_LAT ? S_BURST : S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == 3'd0) state <= S_BURST;
          else lat_cnt <= lat_cnt - 3'd1;
        end
        S_BURST: begin
          if (beat_done) begin
            if (beat_cnt == 4'd0) begin
              state <= S_IDLE;
            end else begin
              addr_q   <= next_addr;
              beat_cnt <= beat_cnt - 4'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
      if (fetch) begin
        rdata <= fetch_err ? 32'd0 : mem[fetch_idx];
        rresp <= fetch_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axi_inst_rom_slave.sv
// Bench for axi_inst_rom_slave: beat-list model plus directed bursts.
module tb_axi_inst_rom_slave;

  localparam longint unsigned BASE  = 64'hBFC0_0000;
  localparam longint unsigned WORDS = 4096;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        arvalid, arvalid0;
  logic        arready, arready0;
  logic [31:0] araddr;
  logic [3:0]  arid, arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rvalid0;
  logic        rready, rready0;
  logic [31:0] rdata, rdata0;
  logic [3:0]  rid, rid0;
  logic [1:0]  rresp, rresp0;
  logic        rlast, rlast0;
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [31:0] ld_data;

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;
  int unsigned due = 0;
  int unsigned last_hs_cyc = 0;
  int unsigned first_valid_cyc = 0;
  bit need_first = 1'b0;

  logic [31:0] mmem [0:WORDS-1];
  beat_t exp_q[$];
  beat_t seen_q[$];

  axi_inst_rom_slave #(.DEPTH_LOG2(12), .ADDR_BASE(32'hBFC0_0000), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst), .rvalid(rvalid),
    .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  axi_inst_rom_slave #(.DEPTH_LOG2(12), .ADDR_BASE(32'hBFC0_0000), .READ_LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .arvalid(arvalid0), .arready(arready0), .araddr(araddr),
    .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst), .rvalid(rvalid0),
    .rready(rready0), .rdata(rdata0), .rid(rid0), .rresp(rresp0), .rlast(rlast0),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected beats of one burst, from the address/range rules directly.
  function automatic void push_burst(input logic [31:0] a, input logic [3:0] len,
                                     input logic [2:0] size, input logic [1:0] burst,
                                     input logic [3:0] id);
    longint unsigned nb, start, cont, wb, ad;
    bit bad_wrap, err;
    beat_t b;
    nb       = 64'd1 << size;
    start    = longint'(a) - (longint'(a) % nb);
    cont     = (longint'(len) + 1) * nb;
    wb       = start - (start % cont);
    bad_wrap = (burst == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15);
    for (int unsigned i = 0; i <= len; i++) begin
      case (burst)
        2'b01:   ad = start + i * nb;
        2'b10:   ad = wb + ((start - wb + i * nb) % cont);
        default: ad = start;
      endcase
      err = (size > 3'd2) || bad_wrap || (ad < BASE) || (ad >= BASE + 4 * WORDS);
      if (err) begin
        b.data = 32'd0;
        b.resp = 2'b10;
      end else begin
        b.data = mmem[(ad - BASE) / 4];
        b.resp = 2'b00;
      end
      b.last = (i == len);
      b.id   = id;
      exp_q.push_back(b);
    end
  endfunction

  // Compare DUT outputs to the model every cycle.
  always @(negedge clk) begin : cmp
    logic exp_valid, exp_ar;
    beat_t b;
    if (reset) begin
      chk("arready_in_reset", {31'd0, arready}, 32'd0);
      exp_q.delete();
    end else begin
      exp_ar    = (exp_q.size() == 0);
      exp_valid = (exp_q.size() != 0) && (cyc >= due);
      chk("arready", {31'd0, arready}, {31'd0, exp_ar});
      chk("rvalid", {31'd0, rvalid}, {31'd0, exp_valid});
      if (exp_valid && rvalid) begin
        b = exp_q[0];
        chk("rdata", rdata, b.data);
        chk("rresp", {30'd0, rresp}, {30'd0, b.resp});
        chk("rlast", {31'd0, rlast}, {31'd0, b.last});
        chk("rid", {28'd0, rid}, {28'd0, b.id});
        if (rready) begin
          seen_q.push_back('{rdata, rresp, rlast, rid});
          void'(exp_q.pop_front());
        end
      end
      if (rvalid && need_first) begin
        first_valid_cyc = cyc;
        need_first = 1'b0;
      end
      if (arvalid && exp_ar) begin
        push_burst(araddr, arlen, arsize, arburst, arid);
        due = cyc + 2;
        last_hs_cyc = cyc;
        need_first = 1'b1;
      end
    end
  end

  task automatic load(input int unsigned idx, input logic [31:0] d);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_addr = 12'(idx); ld_data = d;
    mmem[idx] = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [3:0] len, input logic [2:0] size,
                       input logic [1:0] burst, input logic [3:0] id);
    @(posedge clk); #1;
    araddr = a; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
    @(negedge clk); #1;
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL %s: timeout, %0d beats pending want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_beat(input string name, input int idx, input logic [31:0] d,
                          input logic [1:0] r, input logic l, input logic [3:0] id);
    if (idx >= seen_q.size()) begin
      tests++; fails++;
      $display("FAIL %s: got %0d beats want more than %0d", name, seen_q.size(), idx);
    end else begin
      chk({name, "_data"}, seen_q[idx].data, d);
      chk({name, "_resp"}, {30'd0, seen_q[idx].resp}, {30'd0, r});
      chk({name, "_last"}, {31'd0, seen_q[idx].last}, {31'd0, l});
      chk({name, "_id"}, {28'd0, seen_q[idx].id}, {28'd0, id});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b1; arvalid = 1'b0; arvalid0 = 1'b0; rready = 1'b1; rready0 = 1'b1;
    araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rlast", {31'd0, rlast}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rid", {28'd0, rid}, 32'd0);
    chk("rst_rresp", {30'd0, rresp}, 32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd1);

    load(0, 32'h2408_0001);
    load(1, 32'h2409_0002);
    for (int unsigned w = 2; w < 8; w++) load(w, 32'hAAAA_0000 | w);
    load(4095, 32'hDEAD_0FFF);

    // Fetch pair
    base = seen_q.size();
    do_ar(32'hBFC0_0000, 4'd1, 3'd2, 2'b01, 4'd3);
    wait_done("pair");
    chk_beat("pair_b0", base, 32'h2408_0001, 2'b00, 1'b0, 4'd3);
    chk_beat("pair_b1", base + 1, 32'h2409_0002, 2'b00, 1'b1, 4'd3);
    chk("pair_latency", first_valid_cyc - last_hs_cyc, 32'd2);

    // Backpressure on beat 0 for three cycles
    base = seen_q.size();
    @(posedge clk); #1 rready = 1'b0;
    do_ar(32'hBFC0_0000, 4'd1, 3'd2, 2'b01, 4'd3);
    for (int i = 0; i < 20 && !rvalid; i++) begin
      @(negedge clk); #1;
    end
    chk("bp_rvalid", {31'd0, rvalid}, 32'd1);
    repeat (3) @(posedge clk);
    #1 rready = 1'b1;
    wait_done("backpressure");
    chk_beat("bp_b0", base, 32'h2408_0001, 2'b00, 1'b0, 4'd3);
    chk_beat("bp_b1", base + 1, 32'h2409_0002, 2'b00, 1'b1, 4'd3);

    // WRAP 4 beats from word 2
    base = seen_q.size();
    do_ar(32'hBFC0_0008, 4'd3, 3'd2, 2'b10, 4'd5);
    wait_done("wrap");
    chk_beat("wrap_b0", base, 32'hAAAA_0002, 2'b00, 1'b0, 4'd5);
    chk_beat("wrap_b1", base + 1, 32'hAAAA_0003, 2'b00, 1'b0, 4'd5);
    chk_beat("wrap_b2", base + 2, 32'h2408_0001, 2'b00, 1'b0, 4'd5);
    chk_beat("wrap_b3", base + 3, 32'h2409_0002, 2'b00, 1'b1, 4'd5);

    // INCR crossing the top of memory
    base = seen_q.size();
    do_ar(32'hBFC0_3FFC, 4'd1, 3'd2, 2'b01, 4'd1);
    wait_done("top");
    chk_beat("top_b0", base, 32'hDEAD_0FFF, 2'b00, 1'b0, 4'd1);
    chk_beat("top_b1", base + 1, 32'h0, 2'b10, 1'b1, 4'd1);

    // Below base
    base = seen_q.size();
    do_ar(32'h0000_1000, 4'd1, 3'd2, 2'b01, 4'd2);
    wait_done("low");
    chk_beat("low_b0", base, 32'h0, 2'b10, 1'b0, 4'd2);
    chk_beat("low_b1", base + 1, 32'h0, 2'b10, 1'b1, 4'd2);

    // Oversized beat
    base = seen_q.size();
    do_ar(32'hBFC0_0000, 4'd1, 3'd3, 2'b01, 4'd4);
    wait_done("size3");
    chk_beat("size3_b0", base, 32'h0, 2'b10, 1'b0, 4'd4);
    chk_beat("size3_b1", base + 1, 32'h0, 2'b10, 1'b1, 4'd4);

    // Illegal WRAP length
    base = seen_q.size();
    do_ar(32'hBFC0_0004, 4'd2, 3'd2, 2'b10, 4'd7);
    wait_done("wrap3");
    chk_beat("wrap3_b2", base + 2, 32'h0, 2'b10, 1'b1, 4'd7);

    // Reset after beat 2 of an 8-beat burst
    base = seen_q.size();
    do_ar(32'hBFC0_0000, 4'd7, 3'd2, 2'b01, 4'd6);
    for (int i = 0; i < 40 && seen_q.size() < base + 3; i++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); #1;
    chk("rstmid_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rstmid_arready", {31'd0, arready}, 32'd1);
    chk_beat("rstmid_b2", base + 2, 32'hAAAA_0002, 2'b00, 1'b0, 4'd6);
    base = seen_q.size();
    do_ar(32'hBFC0_0000, 4'd1, 3'd2, 2'b01, 4'd9);
    wait_done("after_rst");
    chk_beat("after_rst_b0", base, 32'h2408_0001, 2'b00, 1'b0, 4'd9);
    chk_beat("after_rst_b1", base + 1, 32'h2409_0002, 2'b00, 1'b1, 4'd9);

    // FIXED, zero latency: three beats of word 5 starting the next cycle
    @(posedge clk); #1;
    araddr = 32'hBFC0_0014; arlen = 4'd2; arsize = 3'd2; arburst = 2'b00; arid = 4'd8;
    arvalid0 = 1'b1;
    @(negedge clk); #1;
    chk("fix_arready", {31'd0, arready0}, 32'd1);
    @(posedge clk); #1 arvalid0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("fix_rvalid", {31'd0, rvalid0}, 32'd1);
      chk("fix_rdata", rdata0, 32'hAAAA_0005);
      chk("fix_rresp", {30'd0, rresp0}, 32'd0);
      chk("fix_rid", {28'd0, rid0}, 32'd8);
      chk("fix_rlast", {31'd0, rlast0}, (k == 2) ? 32'd1 : 32'd0);
    end
    @(negedge clk); #1;
    chk("fix_done_rvalid", {31'd0, rvalid0}, 32'd0);
    chk("fix_done_arready", {31'd0, arready0}, 32'd1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
